mem_read_ctrl: RTL and testbench
================================

Name: mem_read_ctrl

Overview:
- Read-side controller for the multi-cycle data memory: the load counterpart to the write-enabled register/storage path.
- Accepts a load request from the pipeline, issues the read to memory, and honours memory stall/done handshaking.
- Captures returned data into an internal holding register and presents it to the pipeline with a one-cycle valid pulse.
- Drives busy so the pipeline stalls while a read is outstanding.

Parameters:
- WIDTH, 16, data and address width in bits.
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255); used only with RD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req  input  1  pipeline load request; sampled in IDLE and DONE only.
- addr  input  WIDTH  load address; must be even (word aligned).
- busy  output  1  high while a read is outstanding (ISSUE, WAIT).
- data_out  output  WIDTH  last captured read data.
- valid  output  1  one-cycle pulse: data_out is new.
- err  output  1  one-cycle pulse: unaligned request, or timeout.
- mem_rd  output  1  read strobe to memory.
- mem_addr  output  WIDTH  latched read address.
- mem_data  input  WIDTH  memory read data; valid when mem_done=1.
- mem_stall  input  1  memory could not accept the strobe this cycle.
- mem_done  input  1  mem_data valid this cycle.

Behaviour:
- Reset: rst=0 asynchronously forces state=IDLE, data_out=0, valid=0, err=0, mem_addr=0, wait counter=0. mem_rd and busy are 0 in IDLE.
- Reset mid-read: the read is abandoned; no valid pulse follows.
- Reset release: first active edge behaves as IDLE.

State machine (registered state; mem_rd and busy decoded from state):
- IDLE:
  - req=1 with addr[0]=1: err=1 next cycle, no memory access, stay IDLE.
  - req=1 with addr[0]=0: latch addr into mem_addr, go to ISSUE.
- ISSUE:
  - mem_rd=1, busy=1.
  - mem_stall=1: stay in ISSUE; strobe repeats next cycle with the same address.
  - Else mem_done=1 (same-cycle hit): capture mem_data into data_out, go to DONE.
  - Else: go to WAIT, clear counter.
- WAIT:
  - mem_rd=0, busy=1, counter increments each cycle.
  - mem_done=1: capture mem_data, go to DONE.
- DONE:
  - valid=1 for exactly this cycle, busy=0.
  - req is accepted here with the same rules as IDLE, giving back-to-back reads; otherwise go to IDLE.
- Latency: req at edge N; ISSUE in cycle N+1; valid in cycle N+2 on a same-cycle hit. Each WAIT cycle and each stalled ISSUE cycle adds 1.
- Ignored inputs:
  - req in ISSUE or WAIT is ignored (the pipeline must hold it while busy).
  - mem_done in IDLE or DONE is ignored.
  - mem_stall outside ISSUE is ignored.
- data_out holds its value between captures; it is never cleared except by reset.
- valid and err are never high in the same cycle.
- Counter is 8 bits and saturates; it does not wrap.

Optional Feature:
- RD_TIMEOUT_EN defined:
  - In WAIT, if the counter reaches TIMEOUT with no mem_done, pulse err for one cycle and go to IDLE.
  - No valid pulse, data_out unchanged.
  - A late mem_done after the abort is ignored.
- RD_TIMEOUT_EN undefined:
  - Counter logic is absent and WAIT lasts until mem_done.
  - err is raised only by unaligned requests.

Test Plan:
- Reset, then req=1, addr=0x0040, mem_done=1 in ISSUE with mem_data=0xBEEF -> mem_rd high one cycle, mem_addr=0x0040, valid in cycle N+2, data_out=0xBEEF.
- req addr=0x0102, mem_stall=1 for 2 ISSUE cycles, then mem_done after 3 WAIT cycles with data 0x1234 -> mem_rd high 3 cycles, busy high 6 cycles, valid once, data_out=0x1234.
- req addr=0x0003 -> err pulse one cycle, mem_rd never asserted, data_out unchanged.
- Two reads back-to-back (req held through DONE), data 0x1111 then 0x2222 -> two valid pulses 2 cycles apart on hits, data_out sequence 0x1111, 0x2222.
- rst=0 asserted mid-WAIT, then mem_done=1 after release -> outputs at reset values, no valid pulse.
- With RD_TIMEOUT_EN, TIMEOUT=4, mem_done never asserted -> err pulse after 4 WAIT cycles, return to IDLE, a late mem_done is ignored. Without the macro -> busy stays high.

Source files
------------

// File: rtl/mem_read_ctrl.sv
// Read-side controller for the multi-cycle data memory: issues loads, honours stall/done, returns data with a valid pulse.
// Optional macro RD_TIMEOUT_EN aborts a read that sits TIMEOUT cycles in WAIT without mem_done.
//   state   | meaning
//   S_IDLE  | no read outstanding, req sampled
//   S_ISSUE | mem_rd strobe driven, repeats while mem_stall
//   S_WAIT  | strobe accepted, waiting for mem_done
//   S_DONE  | valid pulse, req sampled for back-to-back reads
module mem_read_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] addr,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             err,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_stall,
  input  logic             mem_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_read_ctrl: TIMEOUT must be in 1..255");
  end

`ifdef RD_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef RD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req) begin
          if (addr[0]) begin
            err_d = 1'b1;
          end else begin
            addr_d  = addr;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A stalled strobe wins over a same-cycle mem_done.
        if (!mem_stall) begin
          if (mem_done) begin
            data_d  = mem_data;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
`ifdef RD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          data_d  = mem_data;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
`ifdef RD_TIMEOUT_EN
          if (cnt_q >= CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef RD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mem_rd   = (state_q == S_ISSUE);
  assign data_out = data_q;
  assign mem_addr = addr_q;
  assign valid    = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Scoreboard bench for mem_read_ctrl: randomized loads against a transaction-level latency/data model.
module tb_mem_read_ctrl;
  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst, req, mem_stall, mem_done;
  logic [W-1:0] addr, mem_data;
  logic         busy, valid, err, mem_rd;
  logic [W-1:0] data_out, mem_addr;

  mem_read_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .busy(busy), .data_out(data_out), .valid(valid), .err(err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_stall(mem_stall), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           cyc;
    int           rd;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_data = '0;
  int           rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every valid/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      rd_cnt    = 0;
      last_data = '0;
    end else begin
      if (mem_rd) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stray_mem_rd: got mem_rd=1 expected no read (cycle %0d)", cyc);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        end
      end
      if (valid || err) begin
        chk("valid_err_exclusive", 32'(valid & err), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stray_pulse: got valid=%0b err=%0b expected none (cycle %0d)", valid, err, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_is_err", 32'(err), 32'(mon_e.is_err));
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rd_strobes", 32'(rd_cnt), 32'(mon_e.rd));
          chk("busy_at_pulse", 32'(busy), 32'd0);
          if (!mon_e.is_err) last_data = mon_e.data;
          chk("data_out", 32'(data_out), 32'(last_data));
        end
        rd_cnt = 0;
      end
    end
  end

  // One load: s stalled ISSUE cycles, then hit (w==0) or mem_done in the w-th WAIT cycle.
  task automatic read_txn(input logic [W-1:0] a, input logic [W-1:0] d, input int s, input int w);
    exp_t e;
    req       = 1'b1;
    addr      = a;
    mem_done  = 1'($urandom_range(0, 1));
    mem_stall = 1'($urandom_range(0, 1));
    mem_data  = W'($urandom);
    @(posedge clk); #1;
    req  = 1'b0;
    addr = W'($urandom);
    e.addr = a;
    e.data = d;
    if (a[0]) begin
      e.is_err = 1'b1; e.cyc = cyc; e.rd = 0;
      exp_q.push_back(e);
      mem_done = 1'b0; mem_stall = 1'b0;
      return;
    end
    e.is_err = 1'b0; e.cyc = cyc + 1 + s + w; e.rd = s + 1;
    exp_q.push_back(e);
    repeat (s) begin
      mem_stall = 1'b1;
      mem_done  = 1'($urandom_range(0, 1));
      mem_data  = W'($urandom);
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    if (w == 0) begin
      mem_done = 1'b1; mem_data = d;
      @(posedge clk); #1;
    end else begin
      mem_done = 1'b0; mem_data = W'($urandom);
      @(posedge clk); #1;
      for (int i = 1; i <= w; i++) begin
        chk("busy_in_wait", 32'(busy), 32'd1);
        mem_stall = 1'($urandom_range(0, 1));
        mem_done  = (i == w);
        mem_data  = (i == w) ? d : W'($urandom);
        @(posedge clk); #1;
      end
    end
    mem_done = 1'b0; mem_stall = 1'b0; mem_data = W'($urandom);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   budget;
    rst = 1'b0; req = 1'b0; addr = '0; mem_data = '0; mem_stall = 1'b0; mem_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid",    32'(valid),    32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_mem_rd",   32'(mem_rd),   32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    read_txn(16'h0040, 16'hBEEF, 0, 0);
    @(posedge clk); #1;
    read_txn(16'h0102, 16'h1234, 2, 3);
    @(posedge clk); #1;
    read_txn(16'h0003, 16'h0000, 0, 0);
    @(posedge clk); #1;
    read_txn(16'h1000, 16'h1111, 0, 0);
    read_txn(16'h1002, 16'h2222, 0, 0);
    @(posedge clk); #1;

    // Reset in the middle of WAIT: the read is dropped and a later mem_done is ignored.
    req = 1'b1; addr = 16'h0300;
    @(posedge clk); #1;
    req = 1'b0;
    e.is_err = 1'b0; e.addr = 16'h0300; e.data = 16'h5555; e.cyc = cyc + 10; e.rd = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_valid",    32'(valid),    32'd0);
    chk("midrst_err",      32'(err),      32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_mem_rd",   32'(mem_rd),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_done = 1'b1; mem_data = 16'h5555;
    repeat (3) begin
      @(posedge clk); #1;
      chk("postrst_no_valid", 32'(valid), 32'd0);
      chk("postrst_no_busy",  32'(busy),  32'd0);
    end
    mem_done = 1'b0;

`ifdef RD_TIMEOUT_EN
    req = 1'b1; addr = 16'h0200;
    @(posedge clk); #1;
    req = 1'b0; mem_done = 1'b0;
    e.is_err = 1'b1; e.addr = 16'h0200; e.data = '0; e.cyc = cyc + 1 + TO; e.rd = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    repeat (TO) begin
      chk("busy_before_timeout", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_after_timeout", 32'(busy), 32'd0);
    mem_done = 1'b1; mem_data = 16'hDEAD;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_done_no_valid", 32'(valid), 32'd0);
    end
    mem_done = 1'b0;
`else
    read_txn(16'h0200, 16'hC0DE, 0, 40);
`endif
    @(posedge clk); #1;

    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] a;
      int           s, w, gap;
      a    = W'($urandom);
      a[0] = ($urandom_range(0, 3) == 0);
      s    = $urandom_range(0, 2);
`ifdef RD_TIMEOUT_EN
      w    = $urandom_range(0, TO);
`else
      w    = $urandom_range(0, 5);
`endif
      read_txn(a, W'($urandom), s, w);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        mem_done  = 1'($urandom_range(0, 1));
        mem_stall = 1'($urandom_range(0, 1));
        mem_data  = W'($urandom);
        @(posedge clk); #1;
      end
      mem_done = 1'b0; mem_stall = 1'b0;
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
